bit_sequence_gen: RTL



---
 rtl/bit_sequence_gen.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/bit_sequence_gen.sv
// bit_sequence_gen: serial pattern transmitter.
// Accepts {pattern, len, repeat_cnt} over a valid/ready load handshake and
// shifts the pattern out MSB-first (bit len-1 first), one bit per clock,
// for repeat_cnt passes with GAP_CYCLES idle cycles between passes.
// Optional feature: define SEQ_GEN_PARITY_EN to append an even-parity bit
// after pattern[0] of every pass.
module bit_sequence_gen #(
  parameter int MAX_LEN    = 16,
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [MAX_LEN-1:0]         pattern,
  input  logic [$clog2(MAX_LEN):0]   len,
  input  logic [CNT_W-1:0]           repeat_cnt,
  input  logic                       abort,
  output logic                       out,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int LEN_W = $clog2(MAX_LEN) + 1;
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [IDX_W-1:0]   last_q;    // index of the first bit of a pass (len-1)
  logic [IDX_W-1:0]   bit_idx;   // index of the bit currently on out
  logic [CNT_W-1:0]   passes;    // passes remaining, including the current one
  logic [GAP_W-1:0]   gap_cnt;

  logic [LEN_W-1:0]   len_c;
  logic [IDX_W-1:0]   first_idx;
  logic [IDX_W-1:0]   nxt_idx;
  logic               job_ok;
  logic               pass_end;

`ifdef SEQ_GEN_PARITY_EN
  logic               par_in;
  logic               par_q;
  logic               par_ph;    // parity bit is currently on out

  // Even parity over the low len_c bits of the offered pattern
  always_comb begin
    par_in = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (i < 32'(len_c)) par_in = par_in ^ pattern[i];
    end
  end
`endif

  // Clamp the offered length and derive the start index for a pass
  always_comb begin
    len_c     = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    first_idx = IDX_W'(len_c - LEN_W'(1));
    job_ok    = (len_c != '0) && (repeat_cnt != '0);
    nxt_idx   = bit_idx - IDX_W'(1);
`ifdef SEQ_GEN_PARITY_EN
    pass_end  = par_ph;
`else
    pass_end  = (bit_idx == '0);
`endif
  end

  // Ready is decoded straight from the state
  always_comb begin
    load_ready = (state == IDLE);
  end

  // Job FSM with registered serial outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pat_q     <= '0;
      last_q    <= '0;
      bit_idx   <= '0;
      passes    <= '0;
      gap_cnt   <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      par_q     <= 1'b0;
      par_ph    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            pat_q   <= pattern;
            last_q  <= first_idx;
            bit_idx <= first_idx;
            passes  <= repeat_cnt;
`ifdef SEQ_GEN_PARITY_EN
            par_q   <= par_in;
            par_ph  <= 1'b0;
`endif
            if (job_ok) begin
              state     <= SEND;
              out       <= pattern[first_idx];
              out_valid <= 1'b1;
              busy      <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end

        SEND: begin
          if (abort) begin
            state     <= IDLE;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (pass_end) begin
`ifdef SEQ_GEN_PARITY_EN
            par_ph <= 1'b0;
`endif
            if (passes > CNT_W'(1)) begin
              passes  <= passes - CNT_W'(1);
              bit_idx <= last_q;
              if (GAP_CYCLES > 0) begin
                state     <= GAP;
                out       <= 1'b0;
                out_valid <= 1'b0;
                gap_cnt   <= GAP_W'(GAP_CYCLES - 1);
              end else begin
                out       <= pat_q[last_q];
                out_valid <= 1'b1;
              end
            end else begin
              state     <= IDLE;
              out       <= 1'b0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
`ifdef SEQ_GEN_PARITY_EN
          else if (bit_idx == '0) begin
            out    <= par_q;
            par_ph <= 1'b1;
          end
`endif
          else begin
            bit_idx <= nxt_idx;
            out     <= pat_q[nxt_idx];
          end
        end

        GAP: begin
          if (abort) begin
            state     <= IDLE;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (gap_cnt == '0) begin
            state     <= SEND;
            out       <= pat_q[last_q];
            out_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        default: begin
          state     <= IDLE;
          out       <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
